// File: rtl/wishbone_ram_responder.sv
// Wishbone classic single-access slave backed by a word-organised RAM.
// Each accepted request ends with a single registered ack (in range) or err (out of range).
module wishbone_ram_responder #(
    parameter int          DEPTH       = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int          AW      = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH * 4);
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // 33-bit compare so a window touching the top of the address map cannot wrap.
    function automatic logic addr_hit(input logic [31:0] adr);
        return ({1'b0, adr} >= LO_ADDR) && ({1'b0, adr} < HI_ADDR);
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;

    logic [31:0] mem_q [DEPTH];

    logic [31:0] req_adr_s;
    logic [31:0] req_dat_s;
    logic [3:0]  req_sel_s;
    logic        req_we_s;
    logic [31:0] off_s;
    logic [AW-1:0] idx_s;
    logic        hit_s;
    logic        start_resp_s;
    logic        mem_we_s;
    logic        unused_s;

    // In IDLE the response (zero wait states) uses the live bus; afterwards the latched copy.
    assign req_adr_s = (state_q == S_IDLE) ? wb_adr_i : adr_q;
    assign req_dat_s = (state_q == S_IDLE) ? wb_dat_i : wdat_q;
    assign req_sel_s = (state_q == S_IDLE) ? wb_sel_i : sel_q;
    assign req_we_s  = (state_q == S_IDLE) ? wb_we_i  : we_q;

    assign off_s    = req_adr_s - BASE_ADDR;
    assign idx_s    = off_s[AW+1:2];
    assign hit_s    = addr_hit(req_adr_s);
    assign unused_s = ^{off_s[1:0], off_s[31:AW+2]};

    // Next-state, response and RAM write-enable logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        dat_d        = 32'h0;
        adr_d        = adr_q;
        wdat_d       = wdat_q;
        sel_d        = sel_q;
        we_d         = we_q;
        start_resp_s = 1'b0;
        mem_we_s     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i && !ack_q && !err_q) begin
                    adr_d  = wb_adr_i;
                    wdat_d = wb_dat_i;
                    sel_d  = wb_sel_i;
                    we_d   = wb_we_i;
                    if (WAIT_STATES == 0) begin
                        start_resp_s = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!(wb_cyc_i && wb_stb_i)) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    start_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_resp_s) begin
            state_d = S_RESP;
            if (hit_s) begin
                ack_d = 1'b1;
                if (req_we_s) begin
                    mem_we_s = !rst_i;
                end else begin
                    dat_d = mem_q[idx_s];
                end
            end else begin
                err_d = 1'b1;
            end
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Control and output registers; RAM is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= 32'h0;
            adr_q   <= 32'h0;
            wdat_q  <= 32'h0;
            sel_q   <= 4'h0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
        end
    end

    // Byte-lane RAM write, committed on the edge that raises ack.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (req_sel_s[b]) begin
                    mem_q[idx_s][8*b +: 8] <= req_dat_s[8*b +: 8];
                end
            end
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wishbone_ram_responder.sv
// Directed scoreboard bench: unit 0 is DEPTH=32/BASE=0/no waits, unit 1 is DEPTH=4/BASE=0x10/3 waits.
module tb_wishbone_ram_responder;

    logic        clk;
    logic        rst   [2];
    logic        cyc   [2];
    logic        stb   [2];
    logic        we    [2];
    logic [31:0] adr   [2];
    logic [3:0]  sel   [2];
    logic [31:0] dati  [2];
    logic [31:0] dato  [2];
    logic        ack   [2];
    logic        err   [2];

    typedef struct {
        logic        is_err;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t        sbq [$];
    logic [31:0] mdl [2][32];
    int          checks = 0;
    int          errors = 0;

    wishbone_ram_responder #(.DEPTH(32), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
        .clk_i(clk), .rst_i(rst[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
        .wb_adr_i(adr[0]), .wb_sel_i(sel[0]), .wb_dat_i(dati[0]),
        .wb_dat_o(dato[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0])
    );

    wishbone_ram_responder #(.DEPTH(4), .BASE_ADDR(32'h10), .WAIT_STATES(3)) dut1 (
        .clk_i(clk), .rst_i(rst[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
        .wb_adr_i(adr[1]), .wb_sel_i(sel[1]), .wb_dat_i(dati[1]),
        .wb_dat_o(dato[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws_of(input int u);
        return (u == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] base_of(input int u);
        return (u == 0) ? 32'h0 : 32'h10;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access; the expected response is queued before the bus is driven.
    task automatic xfer(input int u, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic exp_err);
        exp_t e;
        int   widx;
        int   n;
        logic seen;
        widx     = int'((a - base_of(u)) >> 2);
        e.is_err = exp_err;
        e.data   = (exp_err || w) ? 32'h0 : mdl[u][widx];
        e.lat    = 1 + ws_of(u);
        sbq.push_back(e);
        if (!exp_err && w) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) mdl[u][widx][8*b +: 8] = d[8*b +: 8];
            end
        end
        cyc[u] = 1'b1; stb[u] = 1'b1; we[u] = w; adr[u] = a; sel[u] = s; dati[u] = d;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (ack[u] || err[u]) seen = 1'b1;
        end
        cyc[u] = 1'b0; stb[u] = 1'b0;
        e = sbq.pop_front();
        chk("resp_seen", {31'h0, seen}, 32'h1);
        chk("ack", {31'h0, ack[u]}, {31'h0, !e.is_err});
        chk("err", {31'h0, err[u]}, {31'h0, e.is_err});
        chk("rdata", dato[u], e.data);
        chk("latency", n, e.lat);
        @(negedge clk);
        chk("ack_drop", {30'h0, ack[u], err[u]}, 32'h0);
        chk("dat_clear", dato[u], 32'h0);
    endtask

    int acks;
    int overlap;
    int stray;
    logic prev;

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; cyc[u] = 1'b0; stb[u] = 1'b0; we[u] = 1'b0;
            adr[u] = 32'h0; sel[u] = 4'h0; dati[u] = 32'h0;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("reset_out", {dato[u][29:0], ack[u], err[u]}, 32'h0);
        end

        // Basic write/read, zero wait states.
        xfer(0, 1'b1, 32'h4, 4'hF, 32'hDEADBEEF, 1'b0);
        xfer(0, 1'b0, 32'h4, 4'h0, 32'h0, 1'b0);

        // Byte lanes; sel=0 write must leave memory untouched.
        xfer(0, 1'b1, 32'h8, 4'hF, 32'h11223344, 1'b0);
        xfer(0, 1'b1, 32'h8, 4'b0101, 32'hAABBCCDD, 1'b0);
        xfer(0, 1'b1, 32'h8, 4'b0000, 32'hFFFFFFFF, 1'b0);
        xfer(0, 1'b0, 32'h8, 4'h0, 32'h0, 1'b0);
        chk("lane_merge_model", mdl[0][2], 32'h11BB33DD);
        xfer(0, 1'b1, 32'h7C, 4'hF, 32'h0BADF00D, 1'b0);
        xfer(0, 1'b0, 32'h7F, 4'hF, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h80, 4'hF, 32'h0, 1'b1);

        // Decode window 0x10..0x1F with three wait states.
        xfer(1, 1'b1, 32'h1C, 4'hF, 32'h5A5A1234, 1'b0);
        xfer(1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b1);
        xfer(1, 1'b0, 32'h0C, 4'hF, 32'h0, 1'b1);
        xfer(1, 1'b1, 32'h0C, 4'hF, 32'h77777777, 1'b1);
        xfer(1, 1'b0, 32'h1C, 4'hF, 32'h0, 1'b0);

        // Strobe dropped during WAIT: no response, no write.
        xfer(1, 1'b1, 32'h14, 4'hF, 32'h12345678, 1'b0);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h14; sel[1] = 4'hF; dati[1] = 32'hFFFFFFFF;
        stray = 0;
        repeat (2) begin
            @(negedge clk);
            if (ack[1] || err[1]) stray++;
        end
        stb[1] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack[1] || err[1]) stray++;
        end
        cyc[1] = 1'b0;
        chk("abort_no_resp", stray, 0);
        xfer(1, 1'b0, 32'h14, 4'h0, 32'h0, 1'b0);

        // Reset during WAIT of a write: dropped, old word kept.
        xfer(1, 1'b1, 32'h10, 4'hF, 32'hCAFEF00D, 1'b0);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h10; sel[1] = 4'hF; dati[1] = 32'h55;
        repeat (2) @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
        chk("rst_out", {dato[1][29:0], ack[1], err[1]}, 32'h0);
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack[1] || err[1]) stray++;
        end
        chk("rst_no_resp", stray, 0);
        xfer(1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);

        // cyc/stb held high across three reads.
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.is_err = 1'b0; e.data = mdl[0][1]; e.lat = 0;
            sbq.push_back(e);
        end
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h4; sel[0] = 4'hF;
        acks = 0; overlap = 0; prev = 1'b0;
        for (int i = 0; i < 20 && acks < 3; i++) begin
            @(negedge clk);
            if (ack[0]) begin
                exp_t e;
                acks++;
                if (prev) overlap++;
                e = sbq.pop_front();
                chk("held_rdata", dato[0], e.data);
            end
            if (err[0]) overlap++;
            prev = ack[0];
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        chk("held_ack_count", acks, 3);
        chk("held_ack_spacing", overlap, 0);
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack[0] || err[0]) stray++;
        end
        chk("held_no_extra", stray, 0);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
